serial_add_arbiter: RTL and testbench

Shares one bit-serial adder between NREQ requesters, each presenting a pair of WIDTH-bit operands. A round-robin arbiter picks a requester and captures its operands into internal shift registers. The block then runs the LSB-first add over WIDTH cycles and returns the WIDTH+1-bit sum tagged with the winner's index. It sits between several accumulate/compute clients and the single shared serial datapath.

---
 rtl/serial_add_arbiter.sv | 117 +++++++++++
 tb/tb_serial_add_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/serial_add_arbiter.sv
// serial_add_arbiter: NREQ requesters share one LSB-first bit-serial adder.
// A round-robin pick captures the winner's operand pair. WIDTH shift cycles
// follow, then a FINISH cycle publishes {carry, sum} tagged with the winner.
module serial_add_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  resetn,   // active-high despite the name
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] opa,
    input  logic [NREQ*WIDTH-1:0] opb,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic [WIDTH:0]        sum,
    output logic                  done,
    output logic [IDW-1:0]        done_id
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [IDW-1:0]   ptr, winner;

    logic [IDW-1:0]   pick;
    logic             pick_vld;
    logic [WIDTH-1:0] pick_a, pick_b;
    logic             s_bit, c_next;

    // Round-robin search: first asserted req starting just above the last winner.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!pick_vld && req[(int'(ptr) + k) % NREQ]) begin
                pick_vld = 1'b1;
                pick     = IDW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    // Operand mux for the picked requester.
    always_comb begin
        pick_a = '0;
        pick_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (pick == IDW'(k)) begin
                pick_a = opa[k*WIDTH +: WIDTH];
                pick_b = opb[k*WIDTH +: WIDTH];
            end
        end
    end

    // One full-adder slice: the whole serial datapath.
    always_comb begin
        s_bit  = a_sr[0] ^ b_sr[0] ^ carry;
        c_next = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    end

    assign busy = (state != IDLE);

    // Control FSM with registered grant/done/result outputs.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state   <= IDLE;
            gnt     <= '0;
            sum     <= '0;
            done    <= 1'b0;
            done_id <= '0;
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            winner  <= '0;
            ptr     <= IDW'(NREQ - 1);
        end else begin
            gnt  <= '0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        a_sr   <= pick_a;
                        b_sr   <= pick_b;
                        carry  <= 1'b0;
                        cnt    <= '0;
                        winner <= pick;
                        gnt    <= NREQ'(1) << pick;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= c_next;
                    res_sr <= WIDTH'({s_bit, res_sr} >> 1);
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1))
                        state <= FINISH;
                end
                FINISH: begin
                    sum     <= {carry, res_sr};
                    done    <= 1'b1;
                    done_id <= winner;
                    ptr     <= winner;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_arbiter.sv
// Randomized scoreboard bench for serial_add_arbiter.
module tb_serial_add_arbiter;
    localparam int W   = 8;
    localparam int N   = 4;
    localparam int IDW = $clog2(N);

    logic               clk = 1'b0;
    logic               resetn;
    logic [N-1:0]       req;
    logic [N*W-1:0]     opa, opb;
    logic [N-1:0]       gnt;
    logic               busy;
    logic [W:0]         sum;
    logic               done;
    logic [IDW-1:0]     done_id;

    serial_add_arbiter #(.WIDTH(W), .NREQ(N)) dut (
        .clk(clk), .resetn(resetn), .req(req), .opa(opa), .opb(opb),
        .gnt(gnt), .busy(busy), .sum(sum), .done(done), .done_id(done_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IDW-1:0] id;
        logic [W:0]     s;
    } exp_t;

    exp_t           sb[$];
    int             n_checks = 0;
    int             n_pass   = 0;

    // Reference model state: operation timing from the documented latencies.
    int             wait_cnt = 0;   // edges before a new capture is possible
    bit             done_due = 0;
    int             last     = N - 1;
    int             cur_win  = 0;
    logic [W:0]     held_sum = '0;
    logic [IDW-1:0] held_id  = '0;
    logic [N-1:0]   hold     = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Monitor + model, evaluated mid-cycle; predicts the next rising edge.
    always @(negedge clk) begin
        if (resetn) begin
            chk("reset_outs", {gnt, busy, done, sum, done_id}, '0);
            sb.delete();
            wait_cnt = 0; done_due = 0; last = N - 1;
            held_sum = '0; held_id = '0;
        end else begin
            chk("gnt", gnt, (wait_cnt == W + 1) ? (32'd1 << cur_win) : 32'd0);
            chk("busy", busy, (wait_cnt != 0));
            chk("done", done, done_due);
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sum", sum, e.s);
                    chk("done_id", done_id, e.id);
                    held_sum = e.s;
                    held_id  = e.id;
                end
            end else begin
                chk("sum_held", sum, held_sum);
                chk("id_held", done_id, held_id);
            end
            done_due = (wait_cnt == 1);
            if (wait_cnt != 0) begin
                wait_cnt--;
            end else if (|req) begin
                exp_t e;
                int   w;
                w = -1;
                for (int k = 1; k <= N; k++)
                    if (w < 0 && req[(last + k) % N]) w = (last + k) % N;
                e.id = IDW'(w);
                e.s  = {1'b0, opa[w*W +: W]} + {1'b0, opb[w*W +: W]};
                sb.push_back(e);
                cur_win  = w;
                last     = w;
                wait_cnt = W + 1;
            end
        end
    end

    // One cycle; granted requesters drop req unless told to keep holding it.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (gnt[i] && !hold[i]) req[i] = 1'b0;
    endtask

    task automatic raise(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        opa[i*W +: W] = a;
        opb[i*W +: W] = b;
        req[i] = 1'b1;
    endtask

    initial begin
        int t;
        resetn = 1'b1;
        req    = N'($urandom);
        opa    = {$urandom, $urandom};
        opb    = {$urandom, $urandom};
        repeat (4) step();
        req = '0;
        step();
        resetn = 1'b0;
        step();

        // Single requester, then all four with fixed operand pairs.
        raise(0, 8'h25, 8'h12);
        repeat (14) step();
        raise(0, 8'h25, 8'h12);
        raise(1, 8'hCB, 8'h92);
        raise(2, 8'hE9, 8'hA1);
        raise(3, 8'hFF, 8'hFF);
        repeat (45) step();

        // Two requesters holding req continuously must alternate.
        hold = 4'b0101;
        raise(0, 8'($urandom), 8'($urandom));
        raise(2, 8'($urandom), 8'($urandom));
        repeat (50) step();
        hold = '0;
        t = 0;
        while ((req != 0 || busy) && t < 60) begin step(); t++; end
        chk("drain_hold", (t < 60), 1);

        // Reset four cycles into an add: no done, then a fresh add.
        raise(2, 8'hE9, 8'hA1);
        t = 0;
        while (!gnt[2] && t < 30) begin step(); t++; end
        chk("gnt2_wait", gnt[2], 1);
        repeat (4) step();
        resetn = 1'b1;
        repeat (2) step();
        resetn = 1'b0;
        step();
        raise(1, 8'h01, 8'hFF);
        repeat (14) step();

        // Random traffic.
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++)
                if (!req[i] && ($urandom % 4 == 0)) raise(i, 8'($urandom), 8'($urandom));
            step();
        end

        t = 0;
        while ((req != 0 || busy) && t < 100) begin step(); t++; end
        chk("drain_rand", (t < 100), 1);
        repeat (3) step();
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
